// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority,
// long-latency results wait in a small FIFO and drain on idle writeback cycles.
// A scoreboard flags decode sources that still have a queued long-latency write.
module regfile_write_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    input  logic [4:0]  q_rs,
    input  logic [4:0]  q_rt,
    output logic        hazard_rs,
    output logic        hazard_rt,
    output logic        stall_req,
    output logic        reg_we,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    typedef logic [AW:0]   ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam cnt_t LIMIT   = cnt_t'(STARVE_LIMIT);

    // FIFO storage and pointers (one extra MSB distinguishes full from empty)
    logic [4:0]  fifo_addr_q [DEPTH];
    logic [31:0] fifo_data_q [DEPTH];
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;

    // Output stage
    logic        reg_we_q, reg_we_d;
    logic [4:0]  reg_waddr_q, reg_waddr_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic        from_fifo_q, from_fifo_d;

    // Starvation tracking
    cnt_t        starve_q, starve_d;
    logic        stall_q, stall_d;

    logic        full;
    logic        empty;
    logic        wb_win;
    logic        pop;
    logic        push_store;
    logic [4:0]  head_addr;
    logic [31:0] head_data;
    ptr_t        occ;
    ptr_t        slot;
    logic        rs_in_fifo;
    logic        rt_in_fifo;

    assign full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign lu_ready   = !full;
    assign head_addr  = fifo_addr_q[rd_ptr_q[AW-1:0]];
    assign head_data  = fifo_data_q[rd_ptr_q[AW-1:0]];
    // A write to r0 is idle for arbitration; an r0 push is handshaken but not stored
    assign wb_win     = wb_valid && (wb_addr != '0);
    assign push_store = lu_valid && !full && (lu_addr != '0);

    // Arbitration: wb wins; a head colliding with the wb address is stale and dropped
    always_comb begin
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        from_fifo_d = 1'b0;
        pop         = 1'b0;
        if (wb_win) begin
            reg_we_d    = 1'b1;
            reg_waddr_d = wb_addr;
            reg_wdata_d = wb_data;
            if (!empty && (head_addr == wb_addr)) begin
                pop = 1'b1;
            end
        end else if (!empty) begin
            reg_we_d    = 1'b1;
            reg_waddr_d = head_addr;
            reg_wdata_d = head_data;
            from_fifo_d = 1'b1;
            pop         = 1'b1;
        end
    end

    // Pointer advance, starve counter and registered stall request
    always_comb begin
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        wr_ptr_d = push_store ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + CNT_ONE;
        end else begin
            starve_d = starve_q;
        end
        stall_d = (starve_d == LIMIT);
    end

    // Scoreboard search over the occupied FIFO slots
    always_comb begin
        rs_in_fifo = 1'b0;
        rt_in_fifo = 1'b0;
        slot       = '0;
        occ        = wr_ptr_q - rd_ptr_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = rd_ptr_q + ptr_t'(i);
            if (ptr_t'(i) < occ) begin
                if (fifo_addr_q[slot[AW-1:0]] == q_rs) rs_in_fifo = 1'b1;
                if (fifo_addr_q[slot[AW-1:0]] == q_rt) rt_in_fifo = 1'b1;
            end
        end
    end

    assign hazard_rs = (q_rs != '0) &&
                       (rs_in_fifo || (reg_we_q && from_fifo_q && (reg_waddr_q == q_rs)));
    assign hazard_rt = (q_rt != '0) &&
                       (rt_in_fifo || (reg_we_q && from_fifo_q && (reg_waddr_q == q_rt)));

    // FIFO payload write; contents need no reset because the pointers gate validity
    always_ff @(posedge clock) begin
        if (push_store) begin
            fifo_addr_q[wr_ptr_q[AW-1:0]] <= lu_addr;
            fifo_data_q[wr_ptr_q[AW-1:0]] <= lu_data;
        end
    end

    // Control and output-stage state, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            from_fifo_q <= 1'b0;
            starve_q    <= '0;
            stall_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            from_fifo_q <= from_fifo_d;
            starve_q    <= starve_d;
            stall_q     <= stall_d;
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign stall_req = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table for the main scenarios, hand
// sequences for reset mid-stream and the full/wrap boundary. Expected writes
// are queued when stimulus is driven and compared one cycle later.
module tb_regfile_write_arbiter;

    logic        clock;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic [4:0]  q_rs;
    logic [4:0]  q_rt;
    logic        hazard_rs;
    logic        hazard_rt;
    logic        stall_req;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    typedef struct {
        logic        wbv;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        luv;
        logic [4:0]  lua;
        logic [31:0] lud;
        logic [4:0]  qrs;
        logic [4:0]  qrt;
        logic        rdy;
        logic        hrs;
        logic        hrt;
        logic        stl;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[$];

    regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_addr   (lu_addr),
        .lu_data   (lu_data),
        .q_rs      (q_rs),
        .q_rt      (q_rt),
        .hazard_rs (hazard_rs),
        .hazard_rt (hazard_rt),
        .stall_req (stall_req),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare the write the previous cycle's stimulus was expected to produce
    task automatic check_prev();
        wr_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("reg_we", 32'(reg_we), 32'(e.we));
            if (e.we) begin
                chk("reg_waddr", 32'(reg_waddr), 32'(e.wa));
                chk("reg_wdata", reg_wdata, e.wd);
            end
        end
    endtask

    // One clock cycle: check the pending write, drive new inputs, queue expectation
    task automatic cycle(input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                         input logic luv, input logic [4:0] lua, input logic [31:0] lud,
                         input logic [4:0] qrs, input logic [4:0] qrt,
                         input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
        wr_t e;
        @(negedge clock);
        check_prev();
        wb_valid = wbv; wb_addr = wba; wb_data = wbd;
        lu_valid = luv; lu_addr = lua; lu_data = lud;
        q_rs = qrs; q_rt = qrt;
        #1;
        e.we = ewe; e.wa = ewa; e.wd = ewd;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [4:0] qrs, input logic [4:0] qrt);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, qrs, qrt, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        // idle drain of r5
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b1,5'd5,32'hDEADBEEF, 5'd5,5'd0,  1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,        5'd5,5'd0,  1'b1,1'b1,1'b0,1'b0, 1'b1,5'd5,32'hDEADBEEF});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,        5'd5,5'd0,  1'b1,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,        5'd5,5'd0,  1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0});
        // priority, fill, starvation, drain
        vecs.push_back('{1'b1,5'd1,32'h101, 1'b1,5'd10,32'hA0,      5'd10,5'd11,1'b1,1'b0,1'b0,1'b0, 1'b1,5'd1,32'h101});
        vecs.push_back('{1'b1,5'd2,32'h102, 1'b1,5'd11,32'hA1,      5'd10,5'd11,1'b1,1'b1,1'b0,1'b0, 1'b1,5'd2,32'h102});
        vecs.push_back('{1'b1,5'd3,32'h103, 1'b1,5'd12,32'hA2,      5'd10,5'd11,1'b0,1'b1,1'b1,1'b0, 1'b1,5'd3,32'h103});
        vecs.push_back('{1'b1,5'd4,32'h104, 1'b0,5'd0,32'h0,        5'd10,5'd11,1'b0,1'b1,1'b1,1'b0, 1'b1,5'd4,32'h104});
        vecs.push_back('{1'b1,5'd5,32'h105, 1'b0,5'd0,32'h0,        5'd10,5'd11,1'b0,1'b1,1'b1,1'b0, 1'b1,5'd5,32'h105});
        vecs.push_back('{1'b1,5'd6,32'h106, 1'b0,5'd0,32'h0,        5'd10,5'd11,1'b0,1'b1,1'b1,1'b1, 1'b1,5'd6,32'h106});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,        5'd10,5'd11,1'b0,1'b1,1'b1,1'b1, 1'b1,5'd10,32'hA0});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,        5'd10,5'd11,1'b1,1'b1,1'b1,1'b0, 1'b1,5'd11,32'hA1});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,        5'd10,5'd11,1'b1,1'b0,1'b1,1'b0, 1'b0,5'd0,32'h0});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,        5'd10,5'd11,1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0});
        // collision on r7
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b1,5'd7,32'h11,       5'd7,5'd0,  1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0});
        vecs.push_back('{1'b1,5'd7,32'h22,  1'b0,5'd0,32'h0,        5'd7,5'd0,  1'b1,1'b1,1'b0,1'b0, 1'b1,5'd7,32'h22});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,        5'd7,5'd0,  1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,        5'd7,5'd0,  1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0});
        // zero register, then drain during a wb-r0 cycle
        vecs.push_back('{1'b1,5'd0,32'h2,   1'b1,5'd0,32'h1,        5'd0,5'd0,  1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,        5'd0,5'd0,  1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b1,5'd9,32'h99,       5'd0,5'd9,  1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0});
        vecs.push_back('{1'b1,5'd0,32'h2,   1'b0,5'd0,32'h0,        5'd0,5'd9,  1'b1,1'b0,1'b1,1'b0, 1'b1,5'd9,32'h99});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,        5'd0,5'd9,  1'b1,1'b0,1'b1,1'b0, 1'b0,5'd0,32'h0});
        vecs.push_back('{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,        5'd0,5'd9,  1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0});

        // reset state
        reset = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
        q_rs = 5'd3; q_rt = 5'd4;
        #1;
        chk("rst reg_we", 32'(reg_we), 32'h0);
        chk("rst reg_waddr", 32'(reg_waddr), 32'h0);
        chk("rst reg_wdata", reg_wdata, 32'h0);
        chk("rst lu_ready", 32'(lu_ready), 32'h1);
        chk("rst stall_req", 32'(stall_req), 32'h0);
        chk("rst hazard_rs", 32'(hazard_rs), 32'h0);
        chk("rst hazard_rt", 32'(hazard_rt), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // table-driven scenarios
        foreach (vecs[i]) begin
            cycle(vecs[i].wbv, vecs[i].wba, vecs[i].wbd, vecs[i].luv, vecs[i].lua, vecs[i].lud,
                  vecs[i].qrs, vecs[i].qrt, vecs[i].we, vecs[i].wa, vecs[i].wd);
            chk($sformatf("v%0d lu_ready", i), 32'(lu_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d hazard_rs", i), 32'(hazard_rs), 32'(vecs[i].hrs));
            chk($sformatf("v%0d hazard_rt", i), 32'(hazard_rt), 32'(vecs[i].hrt));
            chk($sformatf("v%0d stall_req", i), 32'(stall_req), 32'(vecs[i].stl));
        end

        // reset mid-stream with two entries queued and a write in flight
        cycle(1'b1, 5'd1, 32'h301, 1'b1, 5'd20, 32'hE0, 5'd20, 5'd21, 1'b1, 5'd1, 32'h301);
        cycle(1'b1, 5'd2, 32'h302, 1'b1, 5'd21, 32'hE1, 5'd20, 5'd21, 1'b1, 5'd2, 32'h302);
        @(negedge clock);
        check_prev();
        wb_valid = 1'b0; lu_valid = 1'b0;
        #1;
        chk("pre-rst lu_ready", 32'(lu_ready), 32'h0);
        chk("pre-rst hazard_rs", 32'(hazard_rs), 32'h1);
        chk("pre-rst hazard_rt", 32'(hazard_rt), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid-rst reg_we", 32'(reg_we), 32'h0);
        chk("mid-rst lu_ready", 32'(lu_ready), 32'h1);
        chk("mid-rst hazard_rs", 32'(hazard_rs), 32'h0);
        chk("mid-rst hazard_rt", 32'(hazard_rt), 32'h0);
        chk("mid-rst stall_req", 32'(stall_req), 32'h0);
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle(5'd20, 5'd21);
            chk("post-rst hazard_rs", 32'(hazard_rs), 32'h0);
        end

        // full boundary: push offered while full and a pop happens is rejected
        cycle(1'b1, 5'd1, 32'h201, 1'b1, 5'd12, 32'hB0, 5'd14, 5'd0, 1'b1, 5'd1, 32'h201);
        cycle(1'b1, 5'd2, 32'h202, 1'b1, 5'd13, 32'hB1, 5'd14, 5'd0, 1'b1, 5'd2, 32'h202);
        cycle(1'b0, 5'd0, 32'h0,   1'b1, 5'd14, 32'hB2, 5'd14, 5'd0, 1'b1, 5'd12, 32'hB0);
        chk("full lu_ready", 32'(lu_ready), 32'h0);
        cycle(1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,  5'd14, 5'd0, 1'b1, 5'd13, 32'hB1);
        chk("after-full lu_ready", 32'(lu_ready), 32'h1);
        chk("rejected hazard_rs", 32'(hazard_rs), 32'h0);
        idle(5'd14, 5'd0);
        chk("rejected hazard_rs idle", 32'(hazard_rs), 32'h0);

        // pointer wrap over 10 push/pop rounds
        for (int r = 0; r < 10; r++) begin
            logic [4:0]  a1, a2;
            logic [31:0] d1, d2;
            a1 = 5'(1 + 2 * r);
            a2 = 5'(2 + 2 * r);
            d1 = 32'hC000_0000 + 32'(r);
            d2 = 32'hD000_0000 + 32'(r);
            cycle(1'b0, 5'd0, 32'h0, 1'b1, a1, d1, a1, a2, 1'b0, 5'd0, 32'h0);
            chk("wrap lu_ready a", 32'(lu_ready), 32'h1);
            cycle(1'b0, 5'd0, 32'h0, 1'b1, a2, d2, a1, a2, 1'b1, a1, d1);
            chk("wrap lu_ready b", 32'(lu_ready), 32'h1);
            chk("wrap hazard_rs b", 32'(hazard_rs), 32'h1);
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, a1, a2, 1'b1, a2, d2);
            chk("wrap hazard_rt c", 32'(hazard_rt), 32'h1);
        end
        idle(5'd0, 5'd0);
        @(negedge clock);
        check_prev();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
